// File: rtl/pacman_pkg.sv
// Shared Pac-Man board definitions: tile codes, tile-writer FSM states and default grid size.
package pacman_pkg;

  typedef enum logic [3:0] {
    TILE_EMPTY  = 4'd0,
    TILE_WALL   = 4'd1,
    TILE_FOOD   = 4'd2,
    TILE_PELLET = 4'd3
  } tile_t;

  typedef enum logic [2:0] {
    IDLE,
    RD,
    EVAL,
    WR,
    RESP
  } tw_state_t;

  localparam int unsigned DEF_GRID_W = 20;
  localparam int unsigned DEF_GRID_H = 15;
  localparam int unsigned MOVE_X_W   = 5;
  localparam int unsigned MOVE_Y_W   = 4;
  localparam int unsigned TILE_W     = 4;

endpackage

// File: rtl/board_addr_calc.sv
// Combinational (x,y) -> linear board address plus in-range flag.
// Shared by the tile writer and the display read path.
module board_addr_calc
  import pacman_pkg::*;
#(
  parameter int unsigned GRID_W = DEF_GRID_W,
  parameter int unsigned GRID_H = DEF_GRID_H,
  parameter int unsigned ADDR_W = 9
) (
  input  logic [MOVE_X_W-1:0] x,
  input  logic [MOVE_Y_W-1:0] y,
  output logic [ADDR_W-1:0]   addr,
  output logic                in_range
);

  assign in_range = (32'(x) < GRID_W) && (32'(y) < GRID_H);
  // Row-major layout; arithmetic is unsigned and truncated to the RAM address width.
  assign addr     = ADDR_W'(y) * ADDR_W'(GRID_W) + ADDR_W'(x);

endmodule

// File: rtl/board_tile_writer.sv
// Move-request tile writer: reads the target tile, reports wall/food, clears consumables.
// Optional feature: define POWER_PELLET_EN to make pellets consumable and add power_pulse.
module board_tile_writer
  import pacman_pkg::*;
#(
  parameter int unsigned GRID_W = DEF_GRID_W,
  parameter int unsigned GRID_H = DEF_GRID_H,
  parameter int unsigned ADDR_W = 9,
  parameter int unsigned CNT_W  = 9
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                move_valid,
  output logic                move_ready,
  input  logic [MOVE_X_W-1:0] move_x,
  input  logic [MOVE_Y_W-1:0] move_y,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic                mem_re,
  input  logic [TILE_W-1:0]   mem_rdata,
  output logic                mem_we,
  output logic [TILE_W-1:0]   mem_wdata,
  output logic                resp_valid,
  output logic                resp_blocked,
  output logic                resp_ate,
  output logic [CNT_W-1:0]    food_cnt
`ifdef POWER_PELLET_EN
  ,
  output logic                power_pulse
`endif
);

  tw_state_t         state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              blocked_q, blocked_d;
  logic              ate_q, ate_d;
  logic              food_q, food_d;
  logic [CNT_W-1:0]  food_cnt_q, food_cnt_d;
  logic [ADDR_W-1:0] calc_addr;
  logic              calc_in_range;
`ifdef POWER_PELLET_EN
  logic              pellet_q, pellet_d;
`endif

  board_addr_calc #(
    .GRID_W (GRID_W),
    .GRID_H (GRID_H),
    .ADDR_W (ADDR_W)
  ) u_addr_calc (
    .x        (move_x),
    .y        (move_y),
    .addr     (calc_addr),
    .in_range (calc_in_range)
  );

  always_comb begin
    // NOTE: every _d gets its hold value first, so no branch can leave one unassigned and infer a latch.
    state_d    = state_q;
    addr_d     = addr_q;
    blocked_d  = blocked_q;
    ate_d      = ate_q;
    food_d     = food_q;
    food_cnt_d = food_cnt_q;
`ifdef POWER_PELLET_EN
    pellet_d   = pellet_q;
`endif
    case (state_q)
      IDLE: begin
        if (move_valid) begin
          addr_d    = calc_addr;
          blocked_d = ~calc_in_range;
          ate_d     = 1'b0;
          food_d    = 1'b0;
`ifdef POWER_PELLET_EN
          pellet_d  = 1'b0;
`endif
          state_d   = calc_in_range ? RD : RESP;
        end
      end
      RD:   state_d = EVAL;
      EVAL: begin
        case (tile_t'(mem_rdata))
          TILE_WALL: begin
            blocked_d = 1'b1;
            state_d   = RESP;
          end
          TILE_FOOD: begin
            ate_d   = 1'b1;
            food_d  = 1'b1;
            state_d = WR;
          end
`ifdef POWER_PELLET_EN
          TILE_PELLET: begin
            ate_d    = 1'b1;
            pellet_d = 1'b1;
            state_d  = WR;
          end
`endif
          default: state_d = RESP;
        endcase
      end
      WR: begin
        // Counter sticks at all-ones rather than wrapping back to zero.
        if (food_q && (food_cnt_q != {CNT_W{1'b1}})) begin
          food_cnt_d = food_cnt_q + CNT_W'(1);
        end
        state_d = RESP;
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking <= so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      blocked_q  <= 1'b0;
      ate_q      <= 1'b0;
      food_q     <= 1'b0;
      food_cnt_q <= '0;
`ifdef POWER_PELLET_EN
      pellet_q   <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      blocked_q  <= blocked_d;
      ate_q      <= ate_d;
      food_q     <= food_d;
      food_cnt_q <= food_cnt_d;
`ifdef POWER_PELLET_EN
      pellet_q   <= pellet_d;
`endif
    end
  end

  assign move_ready   = (state_q == IDLE);
  assign mem_re       = (state_q == RD);
  assign mem_we       = (state_q == WR);
  assign mem_wdata    = TILE_EMPTY;
  assign mem_addr     = addr_q;
  assign resp_valid   = (state_q == RESP);
  assign resp_blocked = blocked_q;
  assign resp_ate     = ate_q;
  assign food_cnt     = food_cnt_q;
`ifdef POWER_PELLET_EN
  assign power_pulse  = (state_q == WR) && pellet_q;
`endif

endmodule

// File: tb/tb_board_tile_writer.sv
// Self-checking bench for board_tile_writer: vector table plus response scoreboard.
module tb_board_tile_writer;
  import pacman_pkg::*;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       move_valid = 1'b0;
  logic       move_ready;
  logic [4:0] move_x = '0;
  logic [3:0] move_y = '0;
  logic [8:0] mem_addr;
  logic       mem_re;
  logic [3:0] mem_rdata = 4'hF;
  logic       mem_we;
  logic [3:0] mem_wdata;
  logic       resp_valid;
  logic       resp_blocked;
  logic       resp_ate;
  logic [8:0] food_cnt;
`ifdef POWER_PELLET_EN
  logic       power_pulse;
`endif

  board_tile_writer dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .move_valid   (move_valid),
    .move_ready   (move_ready),
    .move_x       (move_x),
    .move_y       (move_y),
    .mem_addr     (mem_addr),
    .mem_re       (mem_re),
    .mem_rdata    (mem_rdata),
    .mem_we       (mem_we),
    .mem_wdata    (mem_wdata),
    .resp_valid   (resp_valid),
    .resp_blocked (resp_blocked),
    .resp_ate     (resp_ate),
    .food_cnt     (food_cnt)
`ifdef POWER_PELLET_EN
    ,
    .power_pulse  (power_pulse)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0] x;
    logic [3:0] y;
    logic [3:0] rd;
    logic       blk;
    logic       ate;
    logic [8:0] addr;
    int         lat;
    logic       food;
    logic       pel;
  } vec_t;

  typedef struct {
    logic blk;
    logic ate;
    int   lat;
  } resp_t;

  localparam int FOOD_MAX = 511;

  resp_t exp_q[$];
  int    exp_food = 0;
  int    n_checks = 0;
  int    n_errors = 0;
  vec_t  tbl[11];
  vec_t  food_vec;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ready"}, move_ready, 1);
    check({tag, "_re"}, mem_re, 0);
    check({tag, "_we"}, mem_we, 0);
    check({tag, "_resp_valid"}, resp_valid, 0);
    check({tag, "_food_cnt"}, food_cnt, 0);
    check({tag, "_addr"}, mem_addr, 0);
  endtask

  // Drives one move request and follows it cycle by cycle until the response.
  task automatic run_move(input vec_t v, input bit hold, input bit abort_wr);
    int    n_re;
    int    n_we;
    bit    re_prev;
    bit    done;
    resp_t e;
    @(negedge clk);
    check("ready_idle", move_ready, 1);
    move_x     = v.x;
    move_y     = v.y;
    move_valid = 1'b1;
    mem_rdata  = 4'hF;
    @(posedge clk);
    exp_q.push_back('{blk: v.blk, ate: v.ate, lat: v.lat});
    n_re = 0; n_we = 0; re_prev = 1'b0; done = 1'b0;
    for (int cyc = 1; cyc <= 10 && !done; cyc++) begin
      @(negedge clk);
      if (!hold) move_valid = 1'b0;
      mem_rdata = re_prev ? v.rd : 4'hF;
      re_prev   = mem_re;
      check("busy_ready", move_ready, 0);
      check("re_we_excl", mem_re & mem_we, 0);
`ifdef POWER_PELLET_EN
      check("power_pulse", power_pulse, (cyc == 3) && v.pel);
`endif
      if (mem_re) begin
        n_re++;
        check("re_cycle", cyc, 1);
        check("rd_addr", mem_addr, v.addr);
      end
      if (mem_we) begin
        n_we++;
        check("we_cycle", cyc, 3);
        check("wr_addr", mem_addr, v.addr);
        check("wdata", mem_wdata, 0);
        if (abort_wr) begin
          reset_n = 1'b0;
          #1;
          check_reset_outputs("abort");
          exp_q.delete();
          exp_food = 0;
          done = 1'b1;
          for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("abort_no_resp", resp_valid, 0);
          end
          move_valid = 1'b0;
          reset_n = 1'b1;
        end
      end
      if (resp_valid && !done) begin
        e = exp_q.pop_front();
        check("resp_latency", cyc, e.lat);
        check("resp_blocked", resp_blocked, e.blk);
        check("resp_ate", resp_ate, e.ate);
        if (v.food) exp_food = (exp_food >= FOOD_MAX) ? FOOD_MAX : exp_food + 1;
        check("food_cnt", food_cnt, exp_food);
        done = 1'b1;
        if (hold) move_valid = 1'b0;
      end
    end
    check("resp_seen", done, 1);
    check("re_count", n_re, (v.lat != 1) ? 1 : 0);
    check("we_count", n_we, v.ate);
    if (!abort_wr) begin
      @(negedge clk);
      check("resp_pulse_end", resp_valid, 0);
      check("blocked_hold", resp_blocked, v.blk);
      check("ate_hold", resp_ate, v.ate);
      check("ready_after", move_ready, 1);
    end
  endtask

  initial begin
    tbl[0]  = '{5'd3,  4'd2,  4'd2, 1'b0, 1'b1, 9'd43,  4, 1'b1, 1'b0};
    tbl[1]  = '{5'd0,  4'd0,  4'd1, 1'b1, 1'b0, 9'd0,   3, 1'b0, 1'b0};
    tbl[2]  = '{5'd20, 4'd5,  4'd2, 1'b1, 1'b0, 9'd0,   1, 1'b0, 1'b0};
    tbl[3]  = '{5'd19, 4'd14, 4'd0, 1'b0, 1'b0, 9'd299, 3, 1'b0, 1'b0};
    tbl[4]  = '{5'd19, 4'd14, 4'd2, 1'b0, 1'b1, 9'd299, 4, 1'b1, 1'b0};
    tbl[5]  = '{5'd5,  4'd15, 4'd2, 1'b1, 1'b0, 9'd0,   1, 1'b0, 1'b0};
    tbl[6]  = '{5'd31, 4'd15, 4'd1, 1'b1, 1'b0, 9'd0,   1, 1'b0, 1'b0};
`ifdef POWER_PELLET_EN
    tbl[7]  = '{5'd7,  4'd3,  4'd3, 1'b0, 1'b1, 9'd67,  4, 1'b0, 1'b1};
`else
    tbl[7]  = '{5'd7,  4'd3,  4'd3, 1'b0, 1'b0, 9'd67,  3, 1'b0, 1'b0};
`endif
    tbl[8]  = '{5'd10, 4'd7,  4'd9, 1'b0, 1'b0, 9'd150, 3, 1'b0, 1'b0};
    tbl[9]  = '{5'd0,  4'd14, 4'd2, 1'b0, 1'b1, 9'd280, 4, 1'b1, 1'b0};
    tbl[10] = '{5'd19, 4'd0,  4'd1, 1'b1, 1'b0, 9'd19,  3, 1'b0, 1'b0};
    food_vec = tbl[0];

    #2;
    check_reset_outputs("reset");
    check("reset_blocked", resp_blocked, 0);
    check("reset_ate", resp_ate, 0);
    @(negedge clk);
    reset_n = 1'b1;

    foreach (tbl[i]) run_move(tbl[i], 1'b0, 1'b0);

    // Request held high through a whole food transaction: one accept only.
    run_move(food_vec, 1'b1, 1'b0);

    // Reset during the write cycle drops the write and the response.
    run_move(food_vec, 1'b0, 1'b1);
    @(negedge clk);
    check("post_abort_food_cnt", food_cnt, 0);
    run_move(food_vec, 1'b0, 1'b0);
    check("food_after_abort", food_cnt, 1);

    // Saturation of the eaten-food counter.
    for (int n = 0; n < FOOD_MAX + 4; n++) run_move(food_vec, 1'b0, 1'b0);
    check("food_saturated", food_cnt, FOOD_MAX);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
